pps_timebase: RTL



---
 rtl/pps_timebase_if.sv | 43 ++++
 rtl/pps_timebase.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pps_timebase_if.sv
// PPS timebase bundle: the qualified PPS strobe in, disciplined time and status out.
// The master modport is the timebase itself; the slave modport is the PPS source and consumers.
interface pps_timebase_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SEC_W = 32
);
    logic             pps_valid;
    logic             sec_tick;
    logic [SEC_W-1:0] sec_count;
    logic [CNT_W-1:0] subsec_count;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             holdover;
    logic             pps_error;
    logic             pps_missing;

    modport master (
        input  pps_valid,
        output sec_tick,
        output sec_count,
        output subsec_count,
        output period,
        output period_valid,
        output locked,
        output holdover,
        output pps_error,
        output pps_missing
    );

    modport slave (
        output pps_valid,
        input  sec_tick,
        input  sec_count,
        input  subsec_count,
        input  period,
        input  period_valid,
        input  locked,
        input  holdover,
        input  pps_error,
        input  pps_missing
    );
endinterface

// File: rtl/pps_timebase.sv
// PPS-disciplined timebase: measures PPS period, locks after consecutive good periods,
// and keeps seconds/sub-second counters, free-running in holdover when PPS disappears.
module pps_timebase #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned TOL          = 1000,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned HOLDOVER_SEC = 10,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned SEC_W        = 32
) (
    input logic            clk,
    input logic            rst_n,
    pps_timebase_if.master pps_if
);
    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned HoldW = $clog2(HOLDOVER_SEC + 1);

    localparam logic [CNT_W-1:0] PerMin    = CNT_W'(CLK_FREQ - TOL);
    localparam logic [CNT_W-1:0] PerMax    = CNT_W'(CLK_FREQ + TOL);
    localparam logic [CNT_W-1:0] SecLast   = CNT_W'(CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] HoldPhase = CNT_W'(TOL + 1);
    localparam logic [GoodW-1:0] GoodLock  = GoodW'(LOCK_COUNT);
    localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLDOVER_SEC);

    typedef enum logic [1:0] {StIdle, StAcq, StLocked, StHoldover} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [SEC_W-1:0] sec_count_q, sec_count_d;
    logic             sec_tick_q, sec_tick_d;
    logic             period_valid_q, period_valid_d;
    logic             pps_error_q, pps_error_d;
    logic             pps_missing_q, pps_missing_d;
    logic             locked_q, locked_d;
    logic             holdover_q, holdover_d;

    logic [CNT_W-1:0] meas;
    logic [GoodW-1:0] good_inc;
    logic             pps, meas_good, timeout;

    assign pps       = pps_if.pps_valid;
    assign meas      = cnt_q + CNT_W'(1);
    assign meas_good = (meas >= PerMin) && (meas <= PerMax);
    assign timeout   = (cnt_q == PerMax);
    assign good_inc  = good_q + GoodW'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        good_d         = good_q;
        hold_d         = hold_q;
        sec_tick_d     = 1'b0;
        period_valid_d = 1'b0;
        pps_error_d    = 1'b0;
        pps_missing_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pps) begin
                    state_d = StAcq;
                    good_d  = '0;
                end
            end
            StAcq: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pps) begin
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    if (meas_good) begin
                        good_d = good_inc;
                        if (good_inc == GoodLock) begin
                            state_d    = StLocked;
                            sec_tick_d = 1'b1;
                        end
                    end else begin
                        pps_error_d = 1'b1;
                        good_d      = '0;
                    end
                end else if (timeout) begin
                    pps_missing_d = 1'b1;
                    state_d       = StIdle;
                    cnt_d         = '0;
                    good_d        = '0;
                end
            end
            StLocked: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pps) begin
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    if (meas_good) begin
                        sec_tick_d = 1'b1;
                    end else begin
                        pps_error_d = 1'b1;
                        state_d     = StAcq;
                        good_d      = '0;
                    end
                end else if (timeout) begin
                    // The missed second is still ticked; cnt keeps the nominal phase.
                    pps_missing_d = 1'b1;
                    sec_tick_d    = 1'b1;
                    hold_d        = HoldW'(1);
                    cnt_d         = HoldPhase;
                    state_d       = StHoldover;
                end
            end
            StHoldover: begin
                if (pps) begin
                    state_d = StAcq;
                    cnt_d   = '0;
                    good_d  = '0;
                    hold_d  = '0;
                end else if (cnt_q == SecLast) begin
                    cnt_d = '0;
                    if (hold_q == HoldLast) begin
                        state_d = StIdle;
                        hold_d  = '0;
                    end else begin
                        sec_tick_d = 1'b1;
                        hold_d     = hold_q + HoldW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        sec_count_d = sec_count_q + SEC_W'(sec_tick_d);
        locked_d    = (state_d == StLocked);
        holdover_d  = (state_d == StHoldover);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            period_q       <= '0;
            good_q         <= '0;
            hold_q         <= '0;
            sec_count_q    <= '0;
            sec_tick_q     <= 1'b0;
            period_valid_q <= 1'b0;
            pps_error_q    <= 1'b0;
            pps_missing_q  <= 1'b0;
            locked_q       <= 1'b0;
            holdover_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            good_q         <= good_d;
            hold_q         <= hold_d;
            sec_count_q    <= sec_count_d;
            sec_tick_q     <= sec_tick_d;
            period_valid_q <= period_valid_d;
            pps_error_q    <= pps_error_d;
            pps_missing_q  <= pps_missing_d;
            locked_q       <= locked_d;
            holdover_q     <= holdover_d;
        end
    end

    assign pps_if.sec_tick     = sec_tick_q;
    assign pps_if.sec_count    = sec_count_q;
    assign pps_if.subsec_count = cnt_q;
    assign pps_if.period       = period_q;
    assign pps_if.period_valid = period_valid_q;
    assign pps_if.locked       = locked_q;
    assign pps_if.holdover     = holdover_q;
    assign pps_if.pps_error    = pps_error_q;
    assign pps_if.pps_missing  = pps_missing_q;

endmodule
